// File: rtl/exp4_trena_pkg.sv
// Shared definitions for the trena measurement receiver: baud default,
// frame constants, receiver FSM state codes and parser states.
package exp4_trena_pkg;

   localparam int         M_BAUD_PADRAO     = 434;
   localparam logic [6:0] TERMINADOR_PADRAO = 7'h17;
   localparam logic [6:0] ASCII_ZERO        = 7'h30;

   typedef enum logic [3:0] {
      INICIAL  = 4'd0,
      ESPERA   = 4'd1,
      CONFIRMA = 4'd2,
      DADOS    = 4'd3,
      PARIDADE = 4'd4,
      STOP     = 4'd5,
      ARMAZENA = 4'd6
   } rx_estado_t;

   typedef enum logic {
      P_RECEBE   = 1'b0,
      P_DESCARTA = 1'b1
   } parser_t;

   // A digit is 0x30..0x3F: upper three bits equal those of ASCII '0'.
   function automatic logic eh_digito(input logic [6:0] c);
      return (c & 7'h70) == ASCII_ZERO;
   endfunction

endpackage

// File: rtl/exp4_trena_contador_m.sv
// Modulo-M counter with synchronous clear and count enable.
// Ports: clock, reset (async high), zera, conta, q (count), fim (q==M-1).
module contador_m #(
   parameter int M = 16,
   parameter int N = $clog2(M)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   output logic [N-1:0] q,
   output logic         fim
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (zera) begin
         q <= '0;
      end else if (conta) begin
         if (q == N'(M - 1)) q <= '0;
         else                q <= q + 1'b1;
      end
   end

   assign fim = (q == N'(M - 1));

endmodule

// File: rtl/exp4_trena_rx_serial_7E1.sv
// 7E1 async character receiver: sync, start confirm, bit sampling, parity/stop check.
// Ports: clock, reset, entrada_serial -> dados_ascii[6:0], char_ok,
//        char_err_par, char_err_stop (valid in armazena only), db_estado[3:0].
module rx_serial_7E1
   import exp4_trena_pkg::*;
#(
   parameter int M_BAUD = M_BAUD_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       entrada_serial,
   output logic [6:0] dados_ascii,
   output logic       char_ok,
   output logic       char_err_par,
   output logic       char_err_stop,
   output logic [3:0] db_estado
);

   localparam int NB = $clog2(M_BAUD);

   rx_estado_t estado, prox;

   logic          s1, s2, s3;
   logic          queda;
   logic [NB-1:0] baud_q;
   logic          baud_fim, baud_meio;
   logic [2:0]    bit_q;
   logic          bit_fim;
   logic          zera_baud, conta_baud;
   logic          zera_bit, conta_bit;
   logic          amostra_dado, amostra_par, amostra_stop;
   logic [6:0]    dados;
   logic          par_bit, stop_bit;
   logic          par_ok, em_armazena;

   // s1/s2 resynchronise the line; s3 is the previous s2 for edge detect.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= entrada_serial;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign queda     = s3 & ~s2;
   assign baud_meio = (baud_q == NB'(M_BAUD / 2 - 1));

   contador_m #(.M(M_BAUD), .N(NB)) u_baud (
      .clock (clock),
      .reset (reset),
      .zera  (zera_baud),
      .conta (conta_baud),
      .q     (baud_q),
      .fim   (baud_fim)
   );

   contador_m #(.M(7), .N(3)) u_bit (
      .clock (clock),
      .reset (reset),
      .zera  (zera_bit),
      .conta (conta_bit),
      .q     (bit_q),
      .fim   (bit_fim)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= INICIAL;
      else       estado <= prox;
   end

   always_comb begin
      prox         = estado;
      zera_baud    = 1'b0;
      conta_baud   = 1'b0;
      zera_bit     = 1'b0;
      conta_bit    = 1'b0;
      amostra_dado = 1'b0;
      amostra_par  = 1'b0;
      amostra_stop = 1'b0;
      unique case (estado)
         INICIAL: begin
            zera_baud = 1'b1;
            zera_bit  = 1'b1;
            prox      = ESPERA;
         end
         ESPERA: begin
            zera_baud = 1'b1;
            zera_bit  = 1'b1;
            if (queda) prox = CONFIRMA;
         end
         CONFIRMA: begin
            conta_baud = 1'b1;
            if (baud_meio) begin
               // Restart the baud count so data samples land mid-bit.
               zera_baud = 1'b1;
               prox      = s2 ? ESPERA : DADOS;
            end
         end
         DADOS: begin
            conta_baud = 1'b1;
            if (baud_fim) begin
               amostra_dado = 1'b1;
               conta_bit    = 1'b1;
               if (bit_fim) prox = PARIDADE;
            end
         end
         PARIDADE: begin
            conta_baud = 1'b1;
            if (baud_fim) begin
               amostra_par = 1'b1;
               prox        = STOP;
            end
         end
         STOP: begin
            conta_baud = 1'b1;
            if (baud_fim) begin
               amostra_stop = 1'b1;
               prox         = ARMAZENA;
            end
         end
         ARMAZENA: prox = ESPERA;
         default:  prox = INICIAL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dados    <= '0;
         par_bit  <= 1'b0;
         stop_bit <= 1'b0;
      end else begin
         if (amostra_dado) dados[bit_q] <= s2;
         if (amostra_par)  par_bit      <= s2;
         if (amostra_stop) stop_bit     <= s2;
      end
   end

   assign par_ok        = ~(^{dados, par_bit});
   assign em_armazena   = (estado == ARMAZENA);
   assign char_ok       = em_armazena & par_ok & stop_bit;
   assign char_err_par  = em_armazena & ~par_ok;
   assign char_err_stop = em_armazena & ~stop_bit;
   assign dados_ascii   = dados;
   assign db_estado     = estado;

endmodule

// File: rtl/exp4_trena_rx_medida.sv
// Trena link receiver: parses <d0><d1><d2><TERMINADOR> frames into medida.
// Ports: clock, reset (async high), entrada_serial -> medida[11:0], pronto,
//        erro_paridade, erro_quadro (1-cycle pulses), db_estado[3:0].
module exp4_trena_rx_medida
   import exp4_trena_pkg::*;
#(
   parameter int         M_BAUD     = M_BAUD_PADRAO,
   parameter logic [6:0] TERMINADOR = TERMINADOR_PADRAO
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        entrada_serial,
   output logic [11:0] medida,
   output logic        pronto,
   output logic        erro_paridade,
   output logic        erro_quadro,
   output logic [3:0]  db_estado
);

   logic [6:0] c;
   logic       char_ok, char_err_par, char_err_stop;
   logic [1:0] idx;
   logic [3:0] d0, d1, d2;
   parser_t    pst;

   rx_serial_7E1 #(.M_BAUD(M_BAUD)) u_rx (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .dados_ascii    (c),
      .char_ok        (char_ok),
      .char_err_par   (char_err_par),
      .char_err_stop  (char_err_stop),
      .db_estado      (db_estado)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         medida        <= '0;
         pronto        <= 1'b0;
         erro_paridade <= 1'b0;
         erro_quadro   <= 1'b0;
         idx           <= '0;
         d0            <= '0;
         d1            <= '0;
         d2            <= '0;
         pst           <= P_RECEBE;
      end else begin
         pronto        <= 1'b0;
         erro_paridade <= 1'b0;
         erro_quadro   <= 1'b0;
         if (char_err_par || char_err_stop) begin
            erro_paridade <= char_err_par;
            erro_quadro   <= char_err_stop;
            pst           <= P_DESCARTA;
            idx           <= '0;
         end else if (char_ok) begin
            if (pst == P_DESCARTA) begin
               // Resync silently on the next end-of-frame.
               if (c == TERMINADOR) begin
                  pst <= P_RECEBE;
                  idx <= '0;
               end
            end else if (eh_digito(c) && idx != 2'd3) begin
               unique case (idx)
                  2'd0:    d0 <= c[3:0];
                  2'd1:    d1 <= c[3:0];
                  default: d2 <= c[3:0];
               endcase
               idx <= idx + 1'b1;
            end else if (c == TERMINADOR) begin
               if (idx == 2'd3) begin
                  medida <= {d0, d1, d2};
                  pronto <= 1'b1;
               end else begin
                  erro_quadro <= 1'b1;
               end
               idx <= '0;
            end else begin
               erro_quadro <= 1'b1;
               pst         <= P_DESCARTA;
               idx         <= '0;
            end
         end
      end
   end

endmodule
